// File: rtl/real_ball_collector.sv
// real_ball_collector: gathers per-frame ball centroids into a ping-pong pair
// of 7-slot banks and publishes one complete frame at a time to the pattern
// evaluator. Short frames and frames arriving while the evaluator still holds
// the published bank are dropped and counted (saturating at 255).
//
// Handshake: a publish is signalled by a single-cycle data_valid_out pulse;
// the published bank stays stable and the block stays BUSY until the
// evaluator answers with eval_done_in. A frame_done_in that sees BUSY without
// a same-cycle eval_done_in is dropped.
//
// Optional build macro DEDUP_EN: discards incoming centroids that lie within
// MERGE_DIST (Manhattan) of any centroid already stored this frame.
module real_ball_collector #(
    parameter int MAX_SLOTS = 7
`ifdef DEDUP_EN
    ,
    parameter int MERGE_DIST = 8
`endif
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        centroid_valid_in,
    input  logic [10:0] centroid_x_in,
    input  logic [9:0]  centroid_y_in,
    input  logic        frame_done_in,
    input  logic [2:0]  num_balls,
    input  logic        eval_done_in,
    output logic [10:0] real_balls_x [MAX_SLOTS-1:0],
    output logic [9:0]  real_balls_y [MAX_SLOTS-1:0],
    output logic        data_valid_out,
    output logic [2:0]  count_out,
    output logic        overflow_out,
    output logic [7:0]  frames_dropped
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        col_bank_q, col_bank_d;
    logic [2:0]  wr_cnt_q, wr_cnt_d;
    logic        ovf_latch_q, ovf_latch_d;
    logic [10:0] bank_x_q [2][MAX_SLOTS-1:0];
    logic [10:0] bank_x_d [2][MAX_SLOTS-1:0];
    logic [9:0]  bank_y_q [2][MAX_SLOTS-1:0];
    logic [9:0]  bank_y_d [2][MAX_SLOTS-1:0];
    logic [10:0] out_x_q [MAX_SLOTS-1:0];
    logic [10:0] out_x_d [MAX_SLOTS-1:0];
    logic [9:0]  out_y_q [MAX_SLOTS-1:0];
    logic [9:0]  out_y_d [MAX_SLOTS-1:0];
    logic        dv_q, dv_d;
    logic [2:0]  count_q, count_d;
    logic        ovf_out_q, ovf_out_d;
    logic [7:0]  dropped_q, dropped_d;

    logic        is_dup;
    logic        room;
    logic        store;
    logic        spill;
    logic [2:0]  wr_eff;
    logic        ovf_eff;

`ifdef DEDUP_EN
    function automatic logic [11:0] manhattan(input logic [10:0] ax, input logic [10:0] bx,
                                              input logic [9:0] ay, input logic [9:0] by);
        logic [10:0] dx;
        logic [9:0]  dy;
        dx = (ax >= bx) ? (ax - bx) : (bx - ax);
        dy = (ay >= by) ? (ay - by) : (by - ay);
        return {1'b0, dx} + {2'b00, dy};
    endfunction

    // Flag a centroid that duplicates any slot already filled this frame.
    always_comb begin
        is_dup = 1'b0;
        for (int j = 0; j < MAX_SLOTS; j++) begin
            if (j < int'(wr_cnt_q) &&
                manhattan(centroid_x_in, bank_x_q[col_bank_q][j],
                          centroid_y_in, bank_y_q[col_bank_q][j]) < 12'(MERGE_DIST)) begin
                is_dup = 1'b1;
            end
        end
    end
`else
    // Without deduplication every valid centroid is kept.
    always_comb begin
        is_dup = 1'b0;
    end
`endif

    // Collection, publish decision and drop accounting for the current cycle.
    always_comb begin
        state_d     = state_q;
        col_bank_d  = col_bank_q;
        bank_x_d    = bank_x_q;
        bank_y_d    = bank_y_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        dv_d        = 1'b0;
        count_d     = count_q;
        ovf_out_d   = ovf_out_q;
        dropped_d   = dropped_q;

        // A centroid arriving with frame_done_in still belongs to the ending frame.
        room    = (wr_cnt_q < 3'(MAX_SLOTS));
        store   = centroid_valid_in && !is_dup && room;
        spill   = centroid_valid_in && !is_dup && !room;
        wr_eff  = wr_cnt_q + {2'b00, store};
        ovf_eff = ovf_latch_q | spill;
        if (store) begin
            bank_x_d[col_bank_q][wr_cnt_q] = centroid_x_in;
            bank_y_d[col_bank_q][wr_cnt_q] = centroid_y_in;
        end
        wr_cnt_d    = wr_eff;
        ovf_latch_d = ovf_eff;

        // Release comes first so a same-cycle frame end can publish.
        if (state_q == BUSY && eval_done_in) begin
            state_d = IDLE;
        end

        if (frame_done_in) begin
            wr_cnt_d    = 3'd0;
            ovf_latch_d = 1'b0;
            if (num_balls == 3'd0) begin
                // Nothing expected: silently discard.
            end else if (wr_eff < num_balls || state_d == BUSY) begin
                if (dropped_q != 8'hFF) begin
                    dropped_d = dropped_q + 8'd1;
                end
            end else begin
                col_bank_d = ~col_bank_q;
                count_d    = num_balls;
                ovf_out_d  = (wr_eff > num_balls) | ovf_eff;
                dv_d       = 1'b1;
                state_d    = BUSY;
                for (int i = 0; i < MAX_SLOTS; i++) begin
                    out_x_d[i] = (i < int'(num_balls)) ? bank_x_d[col_bank_q][i] : 11'd0;
                    out_y_d[i] = (i < int'(num_balls)) ? bank_y_d[col_bank_q][i] : 10'd0;
                end
            end
        end
    end

    // State, banks and published outputs; reset discards any partial frame.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            col_bank_q  <= 1'b0;
            wr_cnt_q    <= 3'd0;
            ovf_latch_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int s = 0; s < MAX_SLOTS; s++) begin
                    bank_x_q[b][s] <= '0;
                    bank_y_q[b][s] <= '0;
                end
            end
            for (int s = 0; s < MAX_SLOTS; s++) begin
                out_x_q[s] <= '0;
                out_y_q[s] <= '0;
            end
            dv_q      <= 1'b0;
            count_q   <= 3'd0;
            ovf_out_q <= 1'b0;
            dropped_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            col_bank_q  <= col_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            ovf_latch_q <= ovf_latch_d;
            bank_x_q    <= bank_x_d;
            bank_y_q    <= bank_y_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            dv_q        <= dv_d;
            count_q     <= count_d;
            ovf_out_q   <= ovf_out_d;
            dropped_q   <= dropped_d;
        end
    end

    assign real_balls_x   = out_x_q;
    assign real_balls_y   = out_y_q;
    assign data_valid_out = dv_q;
    assign count_out      = count_q;
    assign overflow_out   = ovf_out_q;
    assign frames_dropped = dropped_q;

endmodule

// File: doc/real_ball_collector.md
Name: real_ball_collector

Overview:
Collects per-frame ball centroids streamed by the detection stage into a fixed 7-slot array. Publishes one complete frame at a time to pattern_evaluation as real_balls_x/real_balls_y with a data_valid_out pulse. Uses ping-pong banks, so the next frame is collected while the evaluator works on the current one. Frames with too few detections, or frames that arrive while the evaluator is busy, are dropped and counted.

Parameters:
- MAX_SLOTS, 7: number of slots per bank; fixed to match the evaluator's array depth.
- MERGE_DIST, 8: Manhattan distance in pixels below which two centroids count as duplicates (used only under DEDUP_EN).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset; asynchronous, active-low.
- centroid_valid_in  input  1  a centroid is present this cycle.
- centroid_x_in  input  11  centroid x coordinate.
- centroid_y_in  input  10  centroid y coordinate.
- frame_done_in  input  1  single-cycle pulse marking the end of the current frame's centroids.
- num_balls  input  3  expected ball count; sampled when frame_done_in is high.
- eval_done_in  input  1  pulse from the evaluator's data_valid_out; releases the output bank.
- real_balls_x  output  11 x [6:0]  published bank, x coordinates.
- real_balls_y  output  10 x [6:0]  published bank, y coordinates.
- data_valid_out  output  1  one-cycle pulse when a new bank is published.
- count_out  output  3  number of valid slots in the published bank.
- overflow_out  output  1  published frame had more than num_balls centroids.
- frames_dropped  output  8  saturating count of dropped frames.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs 0; both banks and both slot counts 0.
  - Collect bank = 0; output bank free; overflow latch 0.
  - An in-progress frame is discarded.
- Collect:
  - Each cycle with centroid_valid_in high, the centroid is written to collect-bank slot wr_cnt and wr_cnt increments.
  - Once wr_cnt = 7, further centroids are not stored and the frame's overflow latch is set.
- State machine, two states:
  - IDLE: output bank free.
  - BUSY: output bank held by the evaluator.
  - IDLE -> BUSY on a publish.
  - BUSY -> IDLE on eval_done_in.
- Publish, evaluated on frame_done_in; let N = num_balls:
  - N = 0: frame discarded; no count change.
  - wr_cnt < N: frame dropped; frames_dropped++.
  - State BUSY and no eval_done_in this cycle: frame dropped; frames_dropped++.
  - Otherwise:
    - Swap banks.
    - count_out = N.
    - overflow_out = (wr_cnt > N) or the overflow latch.
    - data_valid_out high the next cycle for exactly 1 cycle.
    - State goes to BUSY.
- Published data:
  - Slots 0..N-1 hold the first N centroids in arrival order; slots N..6 read 0.
  - real_balls_x/real_balls_y/count_out/overflow_out are registered, valid from the data_valid_out cycle, and stable until the next publish.
- After every frame_done_in, wr_cnt and the overflow latch clear, and collection restarts into the (new) collect bank.
- Simultaneous events:
  - centroid_valid_in together with frame_done_in: the centroid belongs to the ending frame and is counted in wr_cnt before the publish decision.
  - eval_done_in together with frame_done_in: the bank is released first, then the publish proceeds.
  - eval_done_in while IDLE: ignored.
- frames_dropped saturates at 255.
- Latency: frame_done_in to data_valid_out is 1 cycle.

Optional Feature:
- Macro: DEDUP_EN.
- Defined:
  - Before storing, the incoming centroid is compared combinationally against every stored slot of the collect bank.
  - If |dx|+|dy| < MERGE_DIST for any slot, the centroid is discarded and wr_cnt is unchanged.
  - A centroid discarded this way never sets overflow.
- Undefined: every valid centroid is stored or counted toward overflow; no comparators are built.

Test Plan:
1. num_balls=3; centroids (100,50),(200,60),(300,70) then frame_done_in -> one cycle later data_valid_out=1 for 1 cycle, count_out=3, slots 0..2 match arrival order, slots 3..6 = 0, overflow_out=0.
2. num_balls=3; only 2 centroids then frame_done_in -> no data_valid_out, frames_dropped=1, output bank unchanged.
3. Publish frame A, no eval_done_in, then send full frame B -> B dropped, frames_dropped=1, outputs still show A; pulse eval_done_in on the same cycle as frame C's frame_done_in -> C published.
4. num_balls=3; 9 centroids -> count_out=3, first 3 stored, overflow_out=1; next clean 3-centroid frame -> overflow_out=0.
5. Assert rst_in low mid-frame after 2 centroids, release, send 3 centroids plus frame_done_in -> published count_out=3 with only the post-reset centroids.
6. DEDUP_EN defined, MERGE_DIST=8; centroids (100,100),(103,102),(200,200),(300,300), num_balls=3 -> slots (100,100),(200,200),(300,300), overflow_out=0. Without DEDUP_EN -> slot 1 = (103,102), overflow_out=1.
